// File: rtl/text_line_fetcher.sv
// Fetches one Apple II text row (40 or 80 columns) from shadow memory into a line buffer
// that the renderer can read at any time with one cycle of latency.
module text_line_fetcher #(
  parameter int unsigned ROWS = 24
) (
  input  logic        clk_logic,
  input  logic        reset,
  input  logic        start_i,
  input  logic [4:0]  row_i,
  input  logic        page2_i,
  input  logic        col80_i,
  output logic [15:0] video_address_o,
  output logic        video_rd_o,
  input  logic [31:0] video_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        line_valid_o,
  input  logic [6:0]  char_col_i,
  output logic [7:0]  char_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  k_q, k_d;
  logic [15:0] addr_q, addr_d;
  logic        col80_q, col80_d;
  logic        cap_valid_q, cap_valid_d;
  logic [4:0]  cap_k_q, cap_k_d;
  logic        line_valid_q, line_valid_d;
  logic [7:0]  char_q, char_d;
  logic [7:0]  buf_q [80];

  logic        accept;
  logic [15:0] base;
  logic [6:0]  widx80, widx40;

  assign accept = (state_q == IDLE) && start_i && (32'(row_i) < ROWS);
  assign base   = 16'h0400 + (page2_i ? 16'h0400 : 16'h0000) + {6'd0, row_i[2:0], 7'd0}
                + ({14'd0, row_i[4:3]} * 16'd40);
  assign widx80 = {cap_k_q, 2'b00};
  assign widx40 = {1'b0, cap_k_q, 1'b0};

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    addr_d       = addr_q;
    col80_d      = col80_q;
    line_valid_d = line_valid_q;
    cap_valid_d  = (state_q == FETCH);
    cap_k_d      = k_q;
    char_d       = (char_col_i < 7'd80) ? buf_q[char_col_i] : 8'h00;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = FETCH;
          k_d          = 5'd0;
          addr_d       = base;
          col80_d      = col80_i;
          line_valid_d = 1'b0;
        end
      end
      FETCH: begin
        if (k_q == 5'd19) begin
          state_d = DRAIN;
        end else begin
          k_d    = k_q + 5'd1;
          addr_d = addr_q + 16'd2;
        end
      end
      DRAIN: begin
        state_d      = DONE;
        line_valid_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_logic) begin
    if (reset) begin
      state_q      <= IDLE;
      k_q          <= 5'd0;
      addr_q       <= 16'h0400;
      col80_q      <= 1'b0;
      cap_valid_q  <= 1'b0;
      cap_k_q      <= 5'd0;
      line_valid_q <= 1'b0;
      char_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      addr_q       <= addr_d;
      col80_q      <= col80_d;
      cap_valid_q  <= cap_valid_d;
      cap_k_q      <= cap_k_d;
      line_valid_q <= line_valid_d;
      char_q       <= char_d;
    end
  end

  // Buffer is not reset; its contents are meaningless until line_valid_o rises.
  always_ff @(posedge clk_logic) begin
    if (cap_valid_q && !reset) begin
      if (col80_q) begin
        buf_q[widx80]         <= video_data_i[15:8];
        buf_q[widx80 + 7'd1]  <= video_data_i[7:0];
        buf_q[widx80 + 7'd2]  <= video_data_i[31:24];
        buf_q[widx80 + 7'd3]  <= video_data_i[23:16];
      end else begin
        buf_q[widx40]         <= video_data_i[7:0];
        buf_q[widx40 + 7'd1]  <= video_data_i[23:16];
      end
    end
  end

  assign video_address_o = addr_q;
  assign video_rd_o      = (state_q == FETCH);
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE);
  assign line_valid_o    = line_valid_q;
  assign char_o          = char_q;

endmodule

// File: tb/tb_text_line_fetcher.sv
// Directed bench for text_line_fetcher: address sequencing, capture layout, rejects and reset abort.
module tb_text_line_fetcher;

  logic        clk_logic = 1'b0;
  logic        reset;
  logic        start_i;
  logic [4:0]  row_i;
  logic        page2_i;
  logic        col80_i;
  logic [15:0] video_address_o;
  logic        video_rd_o;
  logic [31:0] video_data_i;
  logic        busy_o;
  logic        done_o;
  logic        line_valid_o;
  logic [6:0]  char_col_i;
  logic [7:0]  char_o;

  int n_checks = 0;
  int n_pass   = 0;
  bit ovr      = 1'b0;

  text_line_fetcher #(.ROWS(24)) dut (
    .clk_logic       (clk_logic),
    .reset           (reset),
    .start_i         (start_i),
    .row_i           (row_i),
    .page2_i         (page2_i),
    .col80_i         (col80_i),
    .video_address_o (video_address_o),
    .video_rd_o      (video_rd_o),
    .video_data_i    (video_data_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .line_valid_o    (line_valid_o),
    .char_col_i      (char_col_i),
    .char_o          (char_o)
  );

  always #5 clk_logic = ~clk_logic;

  // Shadow memory pattern: main byte = low address byte, aux byte = main ^ A5.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [7:0] me, mo;
    me = a[7:0];
    mo = a[7:0] + 8'd1;
    if (ovr && a == 16'h0400) return 32'hC4C3C2C1;
    return {mo ^ 8'hA5, mo, me ^ 8'hA5, me};
  endfunction

  // Expected 80-column byte for column c of a row starting at base (no override).
  function automatic logic [7:0] exp80(input logic [15:0] base, input int c);
    logic [31:0] w;
    w = mem_word(base + 16'(2 * (c / 4)));
    case (c % 4)
      0:       return w[15:8];
      1:       return w[7:0];
      2:       return w[31:24];
      default: return w[23:16];
    endcase
  endfunction

  always @(posedge clk_logic) begin
    if (video_rd_o) video_data_i <= mem_word(video_address_o);
    else            video_data_i <= 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic read_col(input logic [6:0] col, input logic [7:0] exp);
    @(negedge clk_logic);
    char_col_i = col;
    @(negedge clk_logic);
    check($sformatf("char_col%0d", col), {24'd0, char_o}, {24'd0, exp});
  endtask

  task automatic do_fetch(input logic [4:0] row, input logic pg, input logic c80,
                          input logic [15:0] base, input bit glitch);
    @(negedge clk_logic);
    start_i = 1'b1;
    row_i   = row;
    page2_i = pg;
    col80_i = c80;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_logic);
      start_i = 1'b0;
      if (glitch && c == 5) begin
        start_i = 1'b1;
        row_i   = 5'd3;
      end
      if (c == 1) check("line_valid_clr", {31'd0, line_valid_o}, 32'd0);
      check($sformatf("addr_c%0d", c), {15'd0, video_rd_o, video_address_o},
            {15'd0, 1'b1, base + 16'(2 * (c - 1))});
      if (c == 19 || c == 20) check("done_early", {31'd0, done_o}, 32'd0);
    end
    @(negedge clk_logic);
    start_i = 1'b0;
    check("drain", {14'd0, busy_o, video_rd_o, video_address_o},
          {14'd0, 1'b1, 1'b0, base + 16'd38});
    check("drain_done", {31'd0, done_o}, 32'd0);
    @(negedge clk_logic);
    check("done", {29'd0, done_o, line_valid_o, busy_o}, 32'd7);
    @(negedge clk_logic);
    check("idle", {28'd0, done_o, line_valid_o, busy_o, video_rd_o}, 32'b0100);
    check("idle_addr", {16'd0, video_address_o}, {16'd0, base + 16'd38});
  endtask

  initial begin
    bit saw_done;
    reset      = 1'b1;
    start_i    = 1'b0;
    row_i      = 5'd0;
    page2_i    = 1'b0;
    col80_i    = 1'b0;
    char_col_i = 7'd0;
    repeat (2) @(negedge clk_logic);
    check("rst_state", {11'd0, busy_o, done_o, line_valid_o, video_rd_o, video_address_o,
                        char_o}, {11'd0, 4'b0000, 16'h0400, 8'h00});
    reset = 1'b0;

    // Row 0, page 1, 40 columns
    do_fetch(5'd0, 1'b0, 1'b0, 16'h0400, 1'b0);
    read_col(7'd1, 8'h01);
    read_col(7'd0, 8'h00);
    read_col(7'd39, 8'h27);

    // Row 9 with a start during the fetch that must be ignored
    do_fetch(5'd9, 1'b0, 1'b0, 16'h04A8, 1'b1);
    read_col(7'd2, 8'hAA);

    // Row 24 is out of range
    @(negedge clk_logic);
    start_i = 1'b1;
    row_i   = 5'd24;
    @(negedge clk_logic);
    start_i = 1'b0;
    check("reject_row24", {14'd0, busy_o, line_valid_o, video_address_o},
          {14'd0, 1'b0, 1'b1, 16'h04CE});

    // Row 23, page 2
    do_fetch(5'd23, 1'b1, 1'b0, 16'h0BD0, 1'b0);
    read_col(7'd39, 8'hF7);

    // Row 0, 80 columns with a distinctive first word
    ovr = 1'b1;
    do_fetch(5'd0, 1'b0, 1'b1, 16'h0400, 1'b0);
    read_col(7'd0, 8'hC2);
    read_col(7'd1, 8'hC1);
    read_col(7'd2, 8'hC4);
    read_col(7'd3, 8'hC3);
    read_col(7'd50, exp80(16'h0400, 50));
    read_col(7'd79, 8'h27);
    read_col(7'd80, 8'h00);
    read_col(7'd127, 8'h00);
    ovr = 1'b0;

    // 40-column fetch leaves columns 40..79 untouched
    do_fetch(5'd9, 1'b0, 1'b0, 16'h04A8, 1'b0);
    read_col(7'd50, exp80(16'h0400, 50));
    read_col(7'd1, 8'hA9);

    // Reset on cycle 10 aborts a row 5 fetch; also check read-old-on-write at col 1
    @(negedge clk_logic);
    char_col_i = 7'd1;
    start_i    = 1'b1;
    row_i      = 5'd5;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_logic);
      start_i = 1'b0;
      if (c == 3) check("same_cycle_old", {24'd0, char_o}, 32'hA9);
      if (c == 4) check("after_write", {24'd0, char_o}, 32'h81);
    end
    reset = 1'b1;
    @(negedge clk_logic);
    reset = 1'b0;
    check("abort", {28'd0, busy_o, line_valid_o, video_rd_o, done_o}, 32'd0);
    check("abort_addr", {16'd0, video_address_o}, 32'h0400);
    saw_done = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk_logic);
      if (done_o || busy_o) saw_done = 1'b1;
    end
    check("no_done_after_abort", {31'd0, saw_done}, 32'd0);

    do_fetch(5'd5, 1'b0, 1'b0, 16'h0680, 1'b0);
    read_col(7'd3, 8'h83);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
